// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: two-requester arbiter in front of an Avalon-MM LCD
// controller. It optionally runs the LCD init sequence, then grants whole
// messages round-robin and turns each accepted beat into one held write.
module lcd_bus_arbiter #(
    parameter int INIT_EN = 1,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [8:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [8:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       address,
    output logic       chipselect,
    output logic       byteenable,
    output logic       read,
    output logic       write,
    output logic [7:0] writedata,
    input  logic       waitrequest,
    output logic [1:0] grant,
    output logic       init_done,
    output logic       busy
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_GRANT, S_WRITE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    step;
    logic [CW-1:0] idle_cnt;
    logic          ptr;
    logic          capt_last;
    logic [1:0]    vld;
    logic          owner;
    logic          win;
    logic          accept;
    logic          acc_id;
    logic          done;
    logic          timeout_hit;
    logic [8:0]    sel_data;
    logic          sel_last;

    // LCD init command for a given step
    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign read       = 1'b0;
    assign byteenable = 1'b1;
    assign chipselect = write;
    assign busy       = (state != S_IDLE);
    assign vld        = {req1_valid, req0_valid};
    assign owner      = grant[1];
    // On a tie the requester that was not served last wins.
    assign win        = (vld == 2'b11) ? ~ptr : vld[1];
    assign done       = write & ~waitrequest;
    assign sel_data   = acc_id ? req1_data : req0_data;
    assign sel_last   = acc_id ? req1_last : req0_last;
    assign req0_ready = accept & ~acc_id;
    assign req1_ready = accept & acc_id;

    // Accept decision and next state
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        acc_id      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_INIT: begin
                if (done && step == 2'd3) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                accept = |vld;
                acc_id = win;
                if (accept) state_nxt = S_WRITE;
            end
            S_GRANT: begin
                accept      = vld[owner];
                acc_id      = owner;
                timeout_hit = ~vld[owner] && (idle_cnt == IDLE_LIMIT);
                if (accept)           state_nxt = S_WRITE;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                if (done) state_nxt = capt_last ? S_IDLE : S_GRANT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= (INIT_EN != 0) ? S_INIT : S_IDLE;
        else          state <= state_nxt;
    end

    // Bus outputs, grant, round-robin pointer, idle counter and init step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write     <= 1'b0;
            address   <= 1'b0;
            writedata <= 8'h00;
            grant     <= 2'b00;
            ptr       <= 1'b1;
            idle_cnt  <= '0;
            step      <= 2'd0;
            capt_last <= 1'b0;
            init_done <= (INIT_EN == 0);
        end else begin
            case (state)
                S_INIT: begin
                    if (!write) begin
                        write     <= 1'b1;
                        address   <= 1'b0;
                        writedata <= init_cmd(step);
                    end else if (!waitrequest) begin
                        if (step == 2'd3) begin
                            write     <= 1'b0;
                            writedata <= 8'h00;
                            init_done <= 1'b1;
                        end else begin
                            step      <= step + 2'd1;
                            writedata <= init_cmd(step + 2'd1);
                        end
                    end
                end
                S_IDLE, S_GRANT: begin
                    if (accept) begin
                        write     <= 1'b1;
                        address   <= sel_data[8];
                        writedata <= sel_data[7:0];
                        capt_last <= sel_last;
                        idle_cnt  <= '0;
                        grant     <= acc_id ? 2'b10 : 2'b01;
                    end else if (state == S_GRANT) begin
                        if (timeout_hit) begin
                            grant    <= 2'b00;
                            ptr      <= owner;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (!waitrequest) begin
                        write     <= 1'b0;
                        address   <= 1'b0;
                        writedata <= 8'h00;
                        if (capt_last) begin
                            grant <= 2'b00;
                            ptr   <= owner;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter INIT_EN, default 1: when 1, run the LCD init sequence after reset; when 0, skip it.
REQ-002 SHALL have parameter TIMEOUT, default 255: idle cycles allowed within a held grant before the grant is forced off.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have, for each requester k in {0,1}:
- reqk_valid  in  1  beat k available.
- reqk_data  in  9  bit 8 = LCD address (0 cmd / 1 data), bits 7:0 = byte.
- reqk_last  in  1  beat ends the message.
- reqk_ready  out  1  one-cycle accept pulse.
REQ-005 SHALL have Avalon-MM master ports to the LCD controller:
- address  out  1
- chipselect  out  1
- byteenable  out  1
- read  out  1
- write  out  1
- writedata  out  8
- waitrequest  in  1
REQ-006 SHALL have status ports:
- grant  out  2  one-hot owner; 00 = none.
- init_done  out  1  init sequence complete.
- busy  out  1  state != IDLE.

Function
REQ-007 SHALL implement states INIT, IDLE, GRANT and WRITE.
REQ-008 SHALL tie read=0 and byteenable=1 permanently.
REQ-009 SHALL drive chipselect equal to write.
REQ-010 SHALL drive writedata=0 whenever write=0.
REQ-011 INIT SHALL issue command writes (address=0) in this order: 0x38, 0x0C, 0x06, 0x01.
REQ-012 Each INIT write SHALL be held until a cycle with waitrequest=0.
REQ-013 After the 4th INIT write completes, the next state SHALL be IDLE and init_done SHALL be 1 from that cycle on.
REQ-014 In INIT and WRITE, all reqk_ready SHALL be 0.
REQ-015 Arbitration SHALL occur in IDLE only:
- only one valid: grant it.
- both valid: grant the requester not served last.
- last-served pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 Accept SHALL mean: in IDLE (arbitration winner) or GRANT (holder), with the owner's valid=1, then in the same cycle:
- reqk_ready=1;
- data and last captured into an internal register;
- next state = WRITE.
REQ-017 A beat accepted in cycle N SHALL have write=1 from cycle N+1, with address=captured[8] and writedata=captured[7:0].
REQ-018 write, address and writedata SHALL be held stable until the first cycle with waitrequest=0; that cycle completes the transfer.
REQ-019 The minimum cost SHALL be 2 cycles per beat: accept + 1 write cycle.
REQ-020 On completion with captured last=1:
- next state = IDLE;
- grant=00;
- last-served pointer = owner.
REQ-021 On completion with captured last=0, the next state SHALL be GRANT, with grant held and the other requester blocked.
REQ-022 In GRANT, the idle counter SHALL increment each cycle the owner's valid=0 and clear on accept.
REQ-023 When the idle counter reaches TIMEOUT, the next state SHALL be IDLE, with the grant released and the pointer updated as in REQ-020.
REQ-024 grant SHALL be registered: set on the IDLE accept edge, cleared on release.
REQ-025 A non-owner's valid SHALL never produce a ready pulse.
REQ-026 Requesters SHALL hold data and last stable while valid=1 and ready=0; the block does not check this.

Reset
REQ-027 While reset_n=0 at a clk edge, outputs SHALL take these values:
- write=0, chipselect=0, address=0, writedata=0;
- reqk_ready=0, grant=00, init_done=0;
- idle counter=0, pointer=1;
- INIT step=0.
REQ-028 After reset the state SHALL be INIT when INIT_EN=1; when INIT_EN=0, the state SHALL be IDLE with init_done=1.
REQ-029 Reset mid-transfer SHALL abort it: write=0 at the first reset edge, the captured beat is discarded, and INIT restarts from 0x38.

Verification
REQ-030 Reset, INIT_EN=1, waitrequest=0 -> writes 0x38, 0x0C, 0x06, 0x01 (address 0), each 1 cycle; init_done=1 at the cycle after the 4th write.
REQ-031 req0 sends {0x001, 0x141 last}, waitrequest=0 -> ready0 on cycles N and N+2, write on N+1 and N+3 (address 0 then 1, data 0x01 then 0x41), grant 01 then 00.
REQ-032 Both valid in IDLE, each with a 1-beat message -> req0 served first, then req1, then req0 again under continued tie.
REQ-033 waitrequest=1 for 5 cycles during a write of 0x145 -> write, address=1 and writedata=0x45 held 6 cycles; no ready pulse meanwhile.
REQ-034 req1 holds the grant after a non-last beat, drops valid, TIMEOUT=4, req0 valid -> grant released after 4 idle cycles, then req0 is granted.
REQ-035 reset_n=0 during a held write -> write=0 next cycle; after release, INIT restarts with 0x38.
